// File: rtl/result_writer_pkg.sv
// Shared types and constants for the result writer.
// Holds the default result width, the output FSM state type and the drop-counter width.
package result_writer_pkg;

   localparam int DW_DEF     = 21;
   localparam int DROP_CNT_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

endpackage

// File: rtl/result_writer_if.sv
// Result strobe and memory write-port bundle between accelerator, result writer and memory.
// The slave modport is the result writer's view; master is the surrounding environment.
interface result_writer_if
   import result_writer_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = 8
);

   logic          wr_req;
   logic [DW-1:0] wr_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;

   modport master (
      output wr_req, wr_data, mem_ready,
      input  mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  wr_req, wr_data, mem_ready,
      output mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/result_writer_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and show-ahead read data.
// Latency: pushed word visible at pop_data one edge later; caller must not push when full unless popping.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 21
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          full,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth lets the pointers wrap on natural overflow.
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = empty_q;

endmodule

// File: rtl/result_writer.sv
// Buffers one-cycle result strobes in a FIFO and drains them to memory at consecutive addresses.
// Latency 2 edges strobe-to-mem_we; stalls on mem_ready=0, drops (sticky overflow) when full. Option: RESULT_WRITER_DROP_CNT_EN.
module result_writer
   import result_writer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = DW_DEF,
   parameter int AW    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   result_writer_if.slave        bus,
   input  logic                  clear,
   input  logic [AW-1:0]         base_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
`ifdef RESULT_WRITER_DROP_CNT_EN
   output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
   output logic [AW-1:0]         written_cnt
);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data;
   logic          dropped;

   // A pop is possible from IDLE, or from WRITE once the current word is accepted.
   assign fifo_pop  = !clear && !fifo_empty && ((state_q == IDLE) || bus.mem_ready);
   assign fifo_push = bus.wr_req && !clear && (!fifo_full || fifo_pop);
   assign dropped   = bus.wr_req && !clear && !fifo_push;

   sync_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (clear),
      .push      (fifo_push),
      .push_data (bus.wr_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      if (clear) begin
         state_d = IDLE;
         addr_d  = base_addr;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  mem_wdata_d = fifo_data;
                  mem_addr_d  = addr_q;
                  state_d     = WRITE;
               end
            end
            WRITE: begin
               if (bus.mem_ready) begin
                  addr_d = addr_q + AW'(1);
                  cnt_d  = cnt_q + AW'(1);
                  if (!fifo_empty) begin
                     mem_wdata_d = fifo_data;
                     mem_addr_d  = addr_q + AW'(1);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         if (dropped) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef RESULT_WRITER_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (clear) begin
         drop_d = '0;
      end else if (dropped && (drop_q != '1)) begin
         drop_d = drop_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_q <= '0;
      else      drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;
`endif

   assign bus.mem_we    = (state_q == WRITE);
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign full          = fifo_full;
   assign empty         = fifo_empty;
   assign overflow      = ovf_q;
   assign written_cnt   = cnt_q;

endmodule

// File: doc/result_writer.md
# result_writer

Downstream stage of the exponential accelerator top. It captures each 21-bit result presented on the `wr_req`/`wr_data` strobe into a small FIFO. It drains the FIFO to a result memory through a write port with ready back-pressure, assigning consecutive addresses from a programmable base. This decouples the one-cycle result strobe from a memory that may stall.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DW`, 21: result word width; matches `wr_data`.
- `AW`, 8: memory address width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_req`  in  1  one-cycle result strobe from the accelerator.
- `wr_data`  in  DW  result word; valid only while `wr_req` = 1.
- `clear`  in  1  synchronous flush plus load of the base address.
- `base_addr`  in  AW  start address; sampled only when `clear` = 1.
- `mem_we`  out  1  memory write request (registered).
- `mem_addr`  out  AW  write address (registered).
- `mem_wdata`  out  DW  write data (registered).
- `mem_ready`  in  1  memory accepts the write in a cycle with `mem_we` = 1.
- `full`  out  1  FIFO holds DEPTH words.
- `empty`  out  1  FIFO holds 0 words.
- `overflow`  out  1  sticky: a word arrived while the FIFO was full.
- `written_cnt`  out  AW  completed writes since reset or clear; wraps.

## Operation
- Reset (`rst` = 0) values:
  - `mem_we`, `mem_addr`, `mem_wdata`, `overflow`, `written_cnt`, `full`: 0.
  - `empty`: 1.
  - Address register: 0.
- Push: on `wr_req` = 1, the FIFO accepts the word if `full` = 0, or if a FIFO pop happens in the same cycle. Otherwise the word is dropped and `overflow` is set.
- Output FSM has two states.
  - IDLE (`mem_we` = 0): if the FIFO is non-empty, pop the head into `mem_wdata`, drive `mem_addr` = address register, set `mem_we` = 1, and go to WRITE.
  - WRITE: hold `mem_we`, `mem_addr` and `mem_wdata` stable while `mem_ready` = 0.
  - When `mem_ready` = 1 in WRITE:
    - Increment the address register (mod 2^AW) and `written_cnt`.
    - If the FIFO is non-empty, pop the next word and stay in WRITE. This back-to-back case drives the incremented address.
    - Otherwise drop `mem_we` and go to IDLE.
- `clear` = 1 has priority over every other event in that cycle:
  - FIFO emptied.
  - Output register invalidated (`mem_we` = 0, state IDLE); any write pending in that cycle is abandoned even if `mem_ready` = 1.
  - Address register loaded from `base_addr`.
  - `written_cnt` and `overflow` set to 0.
  - A `wr_req` in the same cycle is discarded and does not set `overflow`.
- Address wrap: after 2^AW − 1, the next address is 0. No error is flagged.

## Timing
- `wr_req` sampled at edge k into an empty FIFO with FSM in IDLE: `mem_we` = 1 after edge k+1.
- Sustained throughput: one word per cycle when `mem_ready` is held at 1.
- `full` and `empty` are registered and reflect the state after each edge.
- Push and pop in the same cycle leave the occupancy unchanged. When full, this does not set `overflow`.
- Reset is asynchronous assert. The design assumes a synchronised deassert. A reset taken mid-write abandons the transfer.

## Configuration
- `RESULT_WRITER_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` (8 bits, reset 0).
  - `drop_cnt` increments on each dropped word, saturates at 255, and is cleared by `clear`.
- Undefined: no port, no counter. `overflow` behaviour is identical in both builds.

## Structure
- Package `result_writer_pkg` holds:
  - The default `DW` value.
  - The FSM state type (IDLE, WRITE).
  - The drop-counter width.
- Sub-module `sync_fifo` (parameters DEPTH, DW) implements:
  - Storage, read/write pointers with wrap, and the occupancy counter.
  - The `full`/`empty` flags and push/pop ports.
- The FSM, address register, counters and `clear` handling live in `result_writer`.

## Test plan
- Single word: `base_addr` = 0x10 with `clear` pulsed; `wr_req` with 0x1ABCD at edge k, `mem_ready` = 1 → exactly one write of 0x1ABCD at `mem_addr` 0x10, `mem_we` high after edge k+1, then `written_cnt` = 1.
- Stall: 3 words pushed while `mem_ready` = 0 for 10 cycles → outputs stay stable at the first word; after release, words are written in order at 0x10, 0x11, 0x12 on consecutive cycles.
- Overflow: `mem_ready` = 0, DEPTH = 4; the FIFO fills (4 words) and the output register holds a fifth. A sixth `wr_req` is dropped and `overflow` = 1. With `RESULT_WRITER_DROP_CNT_EN` defined, `drop_cnt` = 1.
- Full push/pop: FIFO full, `mem_ready` = 1, and `wr_req` in the same cycle → the word is accepted, `overflow` stays 0, and occupancy is unchanged.
- Wrap: `base_addr` = 0xFE, 3 words → addresses 0xFE, 0xFF, 0x00.
- Clear mid-write: `clear` together with `mem_ready` = 1 and `wr_req` = 1 → `mem_we` = 0, `empty` = 1, `written_cnt` = 0, `overflow` = 0, and no subsequent write occurs.
